// File: rtl/ee354_numlock_param_sm.sv
`default_nettype none
// ============================================================================
// Module   : ee354_numlock_param_sm
// Purpose  : Reprogrammable two-button (U = "one", Z = "zero") combination
//            lock. The whole code is always entered before it is judged.
//            Repeated bad attempts force a timed lockout, and the code can be
//            rewritten in the field while the lock is open.
// Ports    : Clk          - system clock, rising-edge active
//            reset_n      - asynchronous active-low reset
//            U, Z         - "one" / "zero" button levels (Clk domain)
//            Prog         - reprogramming request, looked at only while open
//            Unlock       - high while OPENING
//            Locked_out   - high while LOCKOUT
//            Prog_active  - high while PROGRAM
//            state_num    - IDLE=0 ENTER=1 OPENING=2 BAD=3 LOCKOUT=4 PROGRAM=5
//            digit_cnt    - digits accepted in the current entry/program
//            bad_cnt      - consecutive bad attempts (saturating)
//            code_out     - currently active code, MSB entered first
// Revision : 1.0 - initial release
// ============================================================================
module ee354_numlock_param_sm #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
    parameter int                  MAX_BAD        = 3,
    parameter int                  OPEN_CYCLES    = 4,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                              Clk,
    input  logic                              reset_n,
    input  logic                              U,
    input  logic                              Z,
    input  logic                              Prog,
    output logic                              Unlock,
    output logic                              Locked_out,
    output logic                              Prog_active,
    output logic [2:0]                        state_num,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
    output logic [$clog2(MAX_BAD+1)-1:0]      bad_cnt,
    output logic [CODE_LEN-1:0]               code_out
);

    localparam int DW   = $clog2(CODE_LEN + 1);
    localparam int BW   = $clog2(MAX_BAD + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    // A single-cycle timer still needs one bit to hold the value 0.
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER   = 3'd1,
        S_OPENING = 3'd2,
        S_BAD     = 3'd3,
        S_LOCKOUT = 3'd4,
        S_PROGRAM = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                prev_any;
    logic                mismatch;
    logic [TW-1:0]       timer;
    logic [CODE_LEN-1:0] staged;

    logic                any;
    logic                key_event;
    logic                key_valid;
    logic                key_bit;
    logic [DW-1:0]       digit_inc;
    logic                last_digit;
    logic [CODE_LEN-1:0] code_shift;
    logic                exp_bit;
    logic                mismatch_new;
    logic [CODE_LEN:0]   staged_wide;
    logic [CODE_LEN-1:0] staged_next;

    assign any          = U | Z;
    assign key_event    = any & ~prev_any;
    assign key_valid    = U ^ Z;
    assign key_bit      = U;
    assign digit_inc    = digit_cnt + DW'(1);
    assign last_digit   = (digit_inc == DW'(CODE_LEN));
    // Left-shifting by the digits already taken puts the expected digit at the MSB.
    assign code_shift   = code_out << digit_cnt;
    assign exp_bit      = code_shift[CODE_LEN-1];
    assign mismatch_new = mismatch | ~key_valid | (key_bit != exp_bit);
    assign staged_wide  = {staged, key_bit};
    assign staged_next  = staged_wide[CODE_LEN-1:0];
    assign state_num    = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ENTER: begin
                if (key_event) begin
                    if (last_digit) state_next = mismatch_new ? S_BAD : S_OPENING;
                    else            state_next = S_ENTER;
                end
            end
            S_OPENING: begin
                if (Prog)                state_next = S_PROGRAM;
                else if (timer == '0)    state_next = S_IDLE;
            end
            S_BAD: begin
                if (!any) state_next = (bad_cnt == BW'(MAX_BAD)) ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer == '0) state_next = S_IDLE;
            end
            S_PROGRAM: begin
                if (key_event && (!key_valid || last_digit)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            Unlock      <= 1'b0;
            Locked_out  <= 1'b0;
            Prog_active <= 1'b0;
            digit_cnt   <= '0;
            bad_cnt     <= '0;
            code_out    <= CODE;
            mismatch    <= 1'b0;
            timer       <= '0;
            staged      <= '0;
            // Buttons held while reset releases must not look like a new press.
            prev_any    <= 1'b1;
        end else begin
            prev_any    <= any;
            state       <= state_next;
            Unlock      <= (state_next == S_OPENING);
            Locked_out  <= (state_next == S_LOCKOUT);
            Prog_active <= (state_next == S_PROGRAM);

            case (state)
                S_IDLE, S_ENTER: begin
                    if (key_event) begin
                        if (last_digit) begin
                            digit_cnt <= '0;
                            mismatch  <= 1'b0;
                            if (!mismatch_new) begin
                                timer   <= TW'(OPEN_CYCLES - 1);
                                bad_cnt <= '0;
                            end else if (bad_cnt != BW'(MAX_BAD)) begin
                                bad_cnt <= bad_cnt + BW'(1);
                            end
                        end else begin
                            digit_cnt <= digit_inc;
                            mismatch  <= mismatch_new;
                        end
                    end
                end
                S_OPENING: begin
                    if (Prog)              digit_cnt <= '0;
                    else if (timer != '0)  timer     <= timer - TW'(1);
                end
                S_BAD: begin
                    if (!any && (bad_cnt == BW'(MAX_BAD))) timer <= TW'(LOCKOUT_CYCLES - 1);
                end
                S_LOCKOUT: begin
                    if (timer == '0) bad_cnt <= '0;
                    else             timer   <= timer - TW'(1);
                end
                S_PROGRAM: begin
                    if (key_event) begin
                        if (!key_valid) begin
                            digit_cnt <= '0;
                        end else if (last_digit) begin
                            code_out  <= staged_next;
                            digit_cnt <= '0;
                        end else begin
                            staged    <= staged_next;
                            digit_cnt <= digit_inc;
                        end
                    end
                end
                default: begin
                    digit_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ee354_numlock_param_sm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ee354_numlock_param_sm
// Purpose  : Directed self-checking bench for ee354_numlock_param_sm with the
//            default parameters (code 1011, MAX_BAD 3, open 4, lockout 16).
//            Inputs change on the falling edge; outputs are checked on the
//            following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ee354_numlock_param_sm;

    logic       Clk;
    logic       reset_n;
    logic       U;
    logic       Z;
    logic       Prog;
    logic       Unlock;
    logic       Locked_out;
    logic       Prog_active;
    logic [2:0] state_num;
    logic [2:0] digit_cnt;
    logic [1:0] bad_cnt;
    logic [3:0] code_out;

    int errors = 0;
    int checks = 0;
    int n;

    ee354_numlock_param_sm dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .U           (U),
        .Z           (Z),
        .Prog        (Prog),
        .Unlock      (Unlock),
        .Locked_out  (Locked_out),
        .Prog_active (Prog_active),
        .state_num   (state_num),
        .digit_cnt   (digit_cnt),
        .bad_cnt     (bad_cnt),
        .code_out    (code_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic release_keys();
        U = 1'b0; Z = 1'b0; Prog = 1'b0;
        tick();
    endtask

    // Enters four digits MSB first; the last digit is left held.
    task automatic enter_code(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) begin
            U = c[i]; Z = ~c[i];
            tick();
            if (i > 0) begin
                U = 1'b0; Z = 1'b0;
                tick();
            end
        end
    endtask

    // Counts the cycles Unlock stays high, releasing the keys first.
    task automatic count_unlock(output int cnt);
        U = 1'b0; Z = 1'b0;
        cnt = 0;
        while (Unlock && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0; U = 1'b0; Z = 1'b0; Prog = 1'b0;
        tick(); tick();
        check("rst_state",  state_num,   3'd0);
        check("rst_flags",  {Unlock, Locked_out, Prog_active}, 3'b000);
        check("rst_digit",  digit_cnt,   3'd0);
        check("rst_bad",    bad_cnt,     2'd0);
        check("rst_code",   code_out,    4'b1011);
        reset_n = 1'b1;
        tick(); tick();

        // Correct code 1011
        U = 1'b1; Z = 1'b0; tick();
        check("ok_first_state", state_num, 3'd1);
        check("ok_first_digit", digit_cnt, 3'd1);
        release_keys();
        U = 1'b0; Z = 1'b1; tick(); release_keys();
        U = 1'b1; Z = 1'b0; tick(); release_keys();
        U = 1'b1; Z = 1'b0; tick();
        check("ok_open_state", state_num, 3'd2);
        check("ok_open_unlock", Unlock, 1'b1);
        check("ok_open_digit", digit_cnt, 3'd0);
        count_unlock(n);
        check("ok_unlock_len", n, 4);
        check("ok_after_state", state_num, 3'd0);
        check("ok_after_bad", bad_cnt, 2'd0);

        // Wrong code 0011: no early reject, BAD held while button held
        U = 1'b0; Z = 1'b1; tick(); release_keys();
        U = 1'b0; Z = 1'b1; tick(); release_keys();
        U = 1'b1; Z = 1'b0; tick(); release_keys();
        check("bad_no_early_state", state_num, 3'd1);
        check("bad_no_early_digit", digit_cnt, 3'd3);
        U = 1'b1; tick();
        check("bad_state", state_num, 3'd3);
        check("bad_cnt1", bad_cnt, 2'd1);
        tick();
        check("bad_hold_state", state_num, 3'd3);
        release_keys();
        check("bad_release_state", state_num, 3'd0);

        // Two more wrong codes -> lockout
        enter_code(4'b0000); release_keys();
        check("bad_cnt2", bad_cnt, 2'd2);
        check("bad2_idle", state_num, 3'd0);
        enter_code(4'b0111);
        check("bad_cnt3", bad_cnt, 2'd3);
        check("bad3_state", state_num, 3'd3);
        release_keys();
        check("lock_state", state_num, 3'd4);
        n = 0;
        while (Locked_out && n < 40) begin
            n++;
            U = n[0];
            tick();
        end
        check("lock_len", n, 16);
        check("lock_exit_state", state_num, 3'd0);
        check("lock_exit_bad", bad_cnt, 2'd0);
        check("lock_exit_digit", digit_cnt, 3'd0);
        release_keys(); release_keys();

        // Correct code after two bad ones clears bad_cnt
        enter_code(4'b0000); release_keys();
        enter_code(4'b0001); release_keys();
        check("pre_clear_bad", bad_cnt, 2'd2);
        enter_code(4'b1011);
        check("clear_open", state_num, 3'd2);
        check("clear_bad", bad_cnt, 2'd0);
        count_unlock(n);
        release_keys();

        // Reprogram to 0110, Prog in the second OPENING cycle
        enter_code(4'b1011);
        U = 1'b0; Z = 1'b0; tick();
        check("prog_2nd_open", Unlock, 1'b1);
        Prog = 1'b1; tick();
        Prog = 1'b0;
        check("prog_state", state_num, 3'd5);
        check("prog_active", Prog_active, 1'b1);
        check("prog_unlock_low", Unlock, 1'b0);
        check("prog_digit0", digit_cnt, 3'd0);
        enter_code(4'b0110);
        check("prog_code", code_out, 4'b0110);
        check("prog_done_state", state_num, 3'd0);
        check("prog_done_flag", Prog_active, 1'b0);
        release_keys();
        enter_code(4'b1011);
        check("old_code_bad", state_num, 3'd3);
        release_keys();
        enter_code(4'b0110);
        check("new_code_open", state_num, 3'd2);
        count_unlock(n);
        check("new_code_unlock_len", n, 4);
        release_keys();

        // Invalid digit in ENTER is a mismatch
        U = 1'b0; Z = 1'b1; tick(); release_keys();
        U = 1'b1; Z = 1'b0; tick(); release_keys();
        U = 1'b1; Z = 1'b1; tick(); release_keys();
        check("inv_enter_digit", digit_cnt, 3'd3);
        U = 1'b0; Z = 1'b1; tick();
        check("inv_enter_bad", state_num, 3'd3);
        check("inv_enter_badcnt", bad_cnt, 2'd1);
        release_keys();

        // Invalid digit in PROGRAM aborts
        enter_code(4'b0110);
        U = 1'b0; Z = 1'b0; Prog = 1'b1; tick();
        Prog = 1'b0;
        check("inv_prog_state", state_num, 3'd5);
        U = 1'b1; tick(); release_keys();
        Z = 1'b1; tick(); release_keys();
        check("inv_prog_digit2", digit_cnt, 3'd2);
        U = 1'b1; Z = 1'b1; tick();
        check("inv_prog_abort", state_num, 3'd0);
        check("inv_prog_code", code_out, 4'b0110);
        check("inv_prog_digit", digit_cnt, 3'd0);
        release_keys();

        // Asynchronous reset mid-ENTER after reprogramming
        U = 1'b1; tick(); release_keys();
        Z = 1'b1; tick();
        check("mid_enter_digit", digit_cnt, 3'd2);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", state_num, 3'd0);
        check("arst_digit", digit_cnt, 3'd0);
        check("arst_code", code_out, 4'b1011);
        check("arst_flags", {Unlock, Locked_out, Prog_active}, 3'b000);
        Z = 1'b0; U = 1'b1;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        check("held_no_event_state", state_num, 3'd0);
        check("held_no_event_digit", digit_cnt, 3'd0);
        U = 1'b0; tick();
        U = 1'b1; tick();
        check("repress_state", state_num, 3'd1);
        check("repress_digit", digit_cnt, 3'd1);
        release_keys();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
